// File: rtl/writeback_arbiter.sv
// Writeback stage: merges single-cycle ALU results and FIFO-buffered MEM
// results onto the register file's single write port, with starvation guard.
module writeback_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            alu_valid,
    output logic                            alu_ready,
    input  logic [4:0]                      alu_rd,
    input  logic [31:0]                     alu_data,
    input  logic                            mem_valid,
    output logic                            mem_ready,
    input  logic [4:0]                      mem_rd,
    input  logic [31:0]                     mem_data,
    output logic                            reg_write,
    output logic [4:0]                      write_reg,
    output logic [31:0]                     write_data,
    output logic [31:0]                     pending,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]            q_rd   [FIFO_DEPTH];
    logic [31:0]           q_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] q_vld;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [SW-1:0]         starve_cnt;
    logic                  force_mem;
    logic                  fifo_empty;
    logic                  alu_take;
    logic                  push;
    logic                  pop;

    assign fifo_empty = (fifo_count == '0);
    assign force_mem  = (starve_cnt == SW'(STARVE_LIMIT));
    assign mem_ready  = reset && (fifo_count != CW'(FIFO_DEPTH));
    assign alu_ready  = reset && !force_mem;

    // x0 results are consumed but never reach the port or the queue
    assign alu_take = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign push     = mem_valid && mem_ready && (mem_rd != 5'd0);
    assign pop      = reset && !alu_take && !fifo_empty;

    always_comb begin
        pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (q_vld[i]) begin
                pending[q_rd[i]] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= mem_rd;
            q_data[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_write  <= 1'b0;
            write_reg  <= 5'd0;
            write_data <= 32'd0;
            q_vld      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            starve_cnt <= '0;
        end else begin
            reg_write <= alu_take || pop;
            if (alu_take) begin
                write_reg  <= alu_rd;
                write_data <= alu_data;
            end else if (pop) begin
                write_reg  <= q_rd[rd_ptr];
                write_data <= q_data[rd_ptr];
            end

            // push and pop slots never coincide: full blocks push, empty blocks pop
            if (push) begin
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end

            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            if (fifo_empty || pop) begin
                starve_cnt <= '0;
            end else if (alu_take) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: vector table plus hand-written
// starvation and mid-queue reset sequences.
module tb_writeback_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] pending;
    logic [2:0]  fifo_count;

    int total;
    int bad;

    writeback_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk),
        .reset(reset),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_rd(alu_rd),
        .alu_data(alu_data),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_rd(mem_rd),
        .mem_data(mem_data),
        .reg_write(reg_write),
        .write_reg(write_reg),
        .write_data(write_data),
        .pending(pending),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        e_rw;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic [2:0]  e_cnt;
        logic [31:0] e_pend;
        logic        e_mr;
        logic        e_ar;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic av, input logic [4:0] ard,
                         input logic [31:0] adat, input logic mv,
                         input logic [4:0] mrd, input logic [31:0] mdat);
        reset     = rst;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = adat;
        mem_valid = mv;
        mem_rd    = mrd;
        mem_data  = mdat;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // rst av ard adat mv mrd mdat | rw wr wd cnt pend mr ar
        tv[0]  = '{1'b0, 1'b1, 5'd5, 32'h1, 1'b1, 5'd7, 32'h2,
                   1'b0, 5'd0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0};
        tv[1]  = tv[0];
        tv[2]  = tv[0];
        tv[3]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b0, 5'd0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b1};
        tv[4]  = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
                   1'b1, 5'd5, 32'hDEADBEEF, 3'd0, 32'h0, 1'b1, 1'b1};
        tv[5]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678,
                   1'b0, 5'd5, 32'hDEADBEEF, 3'd1, 32'h80, 1'b1, 1'b1};
        tv[6]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b1, 5'd7, 32'h12345678, 3'd0, 32'h0, 1'b1, 1'b1};
        tv[7]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b0, 5'd7, 32'h12345678, 3'd0, 32'h0, 1'b1, 1'b1};
        tv[8]  = '{1'b1, 1'b1, 5'd0, 32'h111, 1'b1, 5'd0, 32'h222,
                   1'b0, 5'd7, 32'h12345678, 3'd0, 32'h0, 1'b1, 1'b1};
        tv[9]  = '{1'b1, 1'b1, 5'd9, 32'hAAAA0009, 1'b1, 5'd10, 32'hBBBB000A,
                   1'b1, 5'd9, 32'hAAAA0009, 3'd1, 32'h400, 1'b1, 1'b1};
        tv[10] = '{1'b1, 1'b1, 5'd0, 32'h333, 1'b1, 5'd0, 32'h444,
                   1'b1, 5'd10, 32'hBBBB000A, 3'd0, 32'h0, 1'b1, 1'b1};
        tv[11] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hC3,
                   1'b0, 5'd10, 32'hBBBB000A, 3'd1, 32'h8, 1'b1, 1'b1};
        tv[12] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hC4,
                   1'b1, 5'd3, 32'hC3, 3'd1, 32'h10, 1'b1, 1'b1};
        tv[13] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b1, 5'd4, 32'hC4, 3'd0, 32'h0, 1'b1, 1'b1};

        for (int i = 0; i < 14; i++) begin
            drive(tv[i].rst, tv[i].av, tv[i].ard, tv[i].adat,
                  tv[i].mv, tv[i].mrd, tv[i].mdat);
            step();
            chk($sformatf("v%0d.reg_write", i), 32'(reg_write), 32'(tv[i].e_rw));
            chk($sformatf("v%0d.write_reg", i), 32'(write_reg), 32'(tv[i].e_wr));
            chk($sformatf("v%0d.write_data", i), write_data, tv[i].e_wd);
            chk($sformatf("v%0d.fifo_count", i), 32'(fifo_count), 32'(tv[i].e_cnt));
            chk($sformatf("v%0d.pending", i), pending, tv[i].e_pend);
            chk($sformatf("v%0d.mem_ready", i), 32'(mem_ready), 32'(tv[i].e_mr));
            chk($sformatf("v%0d.alu_ready", i), 32'(alu_ready), 32'(tv[i].e_ar));
        end

        // Starvation: ALU busy every cycle while four loads queue up
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b1, 5'd1, 32'(k), k < 4, 5'(11 + k), 32'h100 + 32'(k));
            step();
            chk($sformatf("t4.%0d.reg_write", k), 32'(reg_write), 32'd1);
            if (k < 9) begin
                chk($sformatf("t4.%0d.write_reg", k), 32'(write_reg), 32'd1);
                chk($sformatf("t4.%0d.write_data", k), write_data, 32'(k));
                chk($sformatf("t4.%0d.fifo_count", k), 32'(fifo_count),
                    (k < 4) ? 32'(k + 1) : 32'd4);
                chk($sformatf("t4.%0d.alu_ready", k), 32'(alu_ready),
                    (k == 8) ? 32'd0 : 32'd1);
            end else begin
                chk("t4.forced.write_reg", 32'(write_reg), 32'd11);
                chk("t4.forced.write_data", write_data, 32'h100);
                chk("t4.forced.fifo_count", 32'(fifo_count), 32'd3);
                chk("t4.forced.alu_ready", 32'(alu_ready), 32'd1);
            end
            if (k == 3) begin
                chk("t4.full.mem_ready", 32'(mem_ready), 32'd0);
                chk("t4.full.pending", pending, 32'h7800);
            end
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            step();
            chk($sformatf("t4.drain%0d.reg_write", k), 32'(reg_write), 32'd1);
            chk($sformatf("t4.drain%0d.write_reg", k), 32'(write_reg), 32'(12 + k));
            chk($sformatf("t4.drain%0d.write_data", k), write_data,
                32'h101 + 32'(k));
        end
        chk("t4.empty.fifo_count", 32'(fifo_count), 32'd0);

        // Mid-queue reset discards entries for x3/x4/x5
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 5'd1, 32'h55, 1'b1, 5'(3 + k), 32'hE0 + 32'(k));
            step();
        end
        chk("t6.queued.fifo_count", 32'(fifo_count), 32'd3);
        chk("t6.queued.pending", pending, 32'h38);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        chk("t6.rst.fifo_count", 32'(fifo_count), 32'd0);
        chk("t6.rst.pending", pending, 32'h0);
        chk("t6.rst.reg_write", 32'(reg_write), 32'd0);
        chk("t6.rst.write_reg", 32'(write_reg), 32'd0);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("t6.after%0d.reg_write", k), 32'(reg_write), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
